matrix_keypad_scan: RTL and testbench

Scans the 4x4 matrix keypad, debounces press and release, and encodes the active key into the 5-bit `keyvalue` code consumed by the game controller. The game controller one-hot decodes `keyvalue` and edge-detects it, so `keyvalue` holds the key code for the whole press and returns to the no-key code on release. The block sits directly upstream of the game controller, between the keypad pins and the controller.

---
 rtl/whack_a_mole_pkg.sv | 26 ++
 rtl/matrix_keypad_scan_if.sv | 11 +
 rtl/sync2.sv | 27 ++
 rtl/matrix_keypad_scan.sv | 133 +++++++++++++
 tb/tb_matrix_keypad_scan.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/whack_a_mole_pkg.sv
// rtl/whack_a_mole_pkg.sv - shared key codes, keypad scan states and helpers
package whack_a_mole_pkg;

   typedef logic [4:0] key_code_t;

   localparam key_code_t KEY_NONE = 5'b10000;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      SCAN,
      HOLD,
      REL_DB
   } kp_state_t;

   // Lowest-numbered active-low row; only meaningful when at least one bit is 0.
   function automatic logic [1:0] first_low_row(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/matrix_keypad_scan_if.sv
// rtl/matrix_keypad_scan_if.sv - key code bus from the keypad scanner to the game controller
interface matrix_keypad_scan_if;
   import whack_a_mole_pkg::*;

   key_code_t keyvalue;
   logic      keyfinish;

   modport master (output keyvalue, output keyfinish);
   modport slave  (input  keyvalue, input  keyfinish);

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchronizer with selectable reset value
module sync2 #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/matrix_keypad_scan.sv
// rtl/matrix_keypad_scan.sv - 4x4 keypad scanner with press/release debounce and key encoding
module matrix_keypad_scan
   import whack_a_mole_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int SETTLE_CYC   = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [3:0]                  row_in,
   output logic [3:0]                  col_out,
   matrix_keypad_scan_if.master        key_o
);

   // One counter serves both debounce and column settling.
   localparam int CNT_W = $clog2(((DEBOUNCE_CYC > SETTLE_CYC) ? DEBOUNCE_CYC : SETTLE_CYC) + 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   logic [3:0]       row_s;
   kp_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_q, row_d;
   key_code_t        key_q, key_d;
   logic             kf_q, kf_d;

   sync2 #(
      .WIDTH   (4),
      .RST_VAL (4'hF)
   ) u_row_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (row_in),
      .q_o   (row_s)
   );

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         col_q   <= 2'd0;
         row_q   <= 2'd0;
         key_q   <= KEY_NONE;
         kf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         row_q   <= row_d;
         key_q   <= key_d;
         kf_q    <= kf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      row_d   = row_q;
      key_d   = key_q;
      kf_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!(&row_s)) begin
               cnt_d   = '0;
               state_d = PRESS_DB;
            end
         end
         PRESS_DB: begin
            if (&row_s) begin
               state_d = IDLE;
            end else if (cnt_q == DB_LAST) begin
               cnt_d   = '0;
               col_d   = 2'd0;
               state_d = SCAN;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         SCAN: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d = '0;
               if (!(&row_s)) begin
                  row_d   = first_low_row(row_s);
                  key_d   = {1'b0, first_low_row(row_s), col_q};
                  kf_d    = 1'b1;
                  state_d = HOLD;
               end else if (col_q == 2'd3) begin
                  state_d = IDLE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HOLD: begin
            if (row_s[row_q]) begin
               cnt_d   = '0;
               state_d = REL_DB;
            end
         end
         REL_DB: begin
            if (!row_s[row_q]) begin
               state_d = HOLD;
            end else if (cnt_q == DB_LAST) begin
               key_d   = KEY_NONE;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All columns low while waiting for a press, a single column while scanning or holding.
   always_comb begin
      col_out = 4'b0000;
      case (state_q)
         SCAN, HOLD, REL_DB: col_out = ~(4'b0001 << col_q);
         default:            col_out = 4'b0000;
      endcase
   end

   assign key_o.keyvalue  = key_q;
   assign key_o.keyfinish = kf_q;

endmodule

// File: tb/tb_matrix_keypad_scan.sv
// tb/tb_matrix_keypad_scan.sv - directed self-checking bench for matrix_keypad_scan
`timescale 1ns/1ps
module tb_matrix_keypad_scan;

   // Press latency = 15 + 4*col, release latency = 11 (DEBOUNCE_CYC=8, SETTLE_CYC=4),
   // counted in rising edges after the pin changes just past an edge.
   localparam int DB = 8;
   localparam int ST = 4;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [15:0] pressed;

   int n_pass   = 0;
   int n_total  = 0;
   int kf_cnt   = 0;
   int kf_dbl   = 0;
   logic kf_prev = 1'b0;

   matrix_keypad_scan_if key_bus ();

   matrix_keypad_scan #(
      .DEBOUNCE_CYC (DB),
      .SETTLE_CYC   (ST)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .row_in  (row_in),
      .col_out (col_out),
      .key_o   (key_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         row_in[r] = ~(|pressed[r*4 +: 4]) | (|(pressed[r*4 +: 4] & col_out));
      end
   end

   always @(negedge clk) begin
      if (key_bus.keyfinish) begin
         kf_cnt++;
         if (kf_prev) kf_dbl++;
      end
      kf_prev = key_bus.keyfinish;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic wait_kf(input int max, output int lat);
      bit found;
      found = 0;
      lat   = 0;
      while (!found && lat < max) begin
         tick();
         lat++;
         if (key_bus.keyfinish === 1'b1) found = 1;
      end
      if (!found) lat = -1;
   endtask

   task automatic wait_none(input int max, output int lat);
      bit found;
      found = 0;
      lat   = 0;
      while (!found && lat < max) begin
         tick();
         lat++;
         if (key_bus.keyvalue === 5'd16) found = 1;
      end
      if (!found) lat = -1;
   endtask

   initial begin
      int lat;
      int k0;
      int bad;

      rst_n   = 1'b0;
      pressed = '0;
      tick(3);
      chk("reset_keyvalue", key_bus.keyvalue, 16);
      chk("reset_keyfinish", key_bus.keyfinish, 0);
      chk("reset_col_out", col_out, 0);
      rst_n = 1'b1;
      tick(2);
      chk("idle_col_out", col_out, 0);

      // clean press of (2,1)
      k0 = kf_cnt;
      pressed[9] = 1'b1;
      wait_kf(80, lat);
      chk("press9_latency", lat, 19);
      chk("press9_keyvalue", key_bus.keyvalue, 9);
      chk("press9_col_out", col_out, 4'b1101);
      bad = 0;
      repeat (100) begin
         tick();
         if (key_bus.keyvalue !== 5'd9) bad++;
      end
      chk("press9_hold_stable", bad, 0);
      chk("press9_pulse_count", kf_cnt - k0, 1);
      pressed = '0;
      wait_none(60, lat);
      chk("release9_latency", lat, 11);
      chk("release9_col_out", col_out, 0);

      // press bounce only, then bounce followed by stable low on (1,2)
      k0 = kf_cnt;
      for (int i = 0; i < 4; i++) begin
         pressed[6] = 1'b1;
         tick(3);
         pressed[6] = 1'b0;
         tick(3);
      end
      tick(40);
      chk("bounce_only_pulses", kf_cnt - k0, 0);
      chk("bounce_only_keyvalue", key_bus.keyvalue, 16);
      for (int i = 0; i < 4; i++) begin
         pressed[6] = 1'b1;
         tick(3);
         pressed[6] = 1'b0;
         tick(3);
      end
      pressed[6] = 1'b1;
      wait_kf(80, lat);
      chk("bounce_press_latency", lat, 23);
      chk("bounce_press_keyvalue", key_bus.keyvalue, 6);
      tick(5);
      chk("bounce_press_pulses", kf_cnt - k0, 1);
      pressed = '0;
      wait_none(60, lat);
      chk("bounce_release_latency", lat, 11);

      // release bounce on (0,2)
      k0 = kf_cnt;
      pressed[2] = 1'b1;
      wait_kf(80, lat);
      chk("relb_press_latency", lat, 23);
      chk("relb_keyvalue", key_bus.keyvalue, 2);
      tick(5);
      pressed[2] = 1'b0;
      tick(3);
      pressed[2] = 1'b1;
      tick(30);
      chk("relb_keyvalue_kept", key_bus.keyvalue, 2);
      chk("relb_pulses", kf_cnt - k0, 1);
      pressed = '0;
      wait_none(60, lat);
      chk("relb_final_release", lat, 11);

      // (0,3) and (3,0) together: column 0 is scanned first
      k0 = kf_cnt;
      pressed[3]  = 1'b1;
      pressed[12] = 1'b1;
      wait_kf(80, lat);
      chk("multi_latency", lat, 15);
      chk("multi_keyvalue", key_bus.keyvalue, 12);
      tick(10);
      chk("multi_pulses", kf_cnt - k0, 1);
      pressed = '0;
      wait_none(60, lat);
      chk("multi_release", lat, 11);

      // key 15 twice
      k0 = kf_cnt;
      pressed[15] = 1'b1;
      wait_kf(80, lat);
      chk("k15a_latency", lat, 27);
      chk("k15a_keyvalue", key_bus.keyvalue, 15);
      tick(10);
      pressed = '0;
      wait_none(60, lat);
      chk("k15a_release", lat, 11);
      pressed[15] = 1'b1;
      wait_kf(80, lat);
      chk("k15b_latency", lat, 27);
      chk("k15b_keyvalue", key_bus.keyvalue, 15);
      tick(10);
      chk("k15_pulses", kf_cnt - k0, 2);
      pressed = '0;
      wait_none(60, lat);
      chk("k15b_release", lat, 11);

      // asynchronous reset during HOLD of (1,3), cancelling the live pulse
      k0 = kf_cnt;
      pressed[7] = 1'b1;
      wait_kf(80, lat);
      chk("rst_press_latency", lat, 27);
      chk("rst_press_keyvalue", key_bus.keyvalue, 7);
      rst_n = 1'b0;
      #1;
      chk("rst_async_keyvalue", key_bus.keyvalue, 16);
      chk("rst_async_keyfinish", key_bus.keyfinish, 0);
      chk("rst_async_col_out", col_out, 0);
      tick(3);
      rst_n = 1'b1;
      wait_kf(80, lat);
      chk("rst_repress_latency", lat, 27);
      chk("rst_repress_keyvalue", key_bus.keyvalue, 7);
      tick(5);
      chk("rst_pulses", kf_cnt - k0, 1);
      pressed = '0;
      wait_none(60, lat);
      chk("rst_release", lat, 11);

      chk("no_back_to_back_pulse", kf_dbl, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
